// File: rtl/post_normalizer.sv
// post_normalizer: back end of the float-add datapath. Normalizes the raw
// 28-bit mantissa sum one bit per cycle, rounds (RNE or truncate) and packs
// an IEEE-754 single. One operation in flight, valid/ready on both sides.
module post_normalizer #(
    parameter bit          ROUND_EN    = 1'b1,
    parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_mantis,
    input  logic        in_inf,
    input  logic        in_nan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_inexact
);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    typedef struct packed {
        logic [31:0] word;
        logic        ovf;
        logic        inx;
    } pack_t;

    state_t      state, state_nxt;
    logic        sign_r;
    logic [8:0]  exp_r;
    logic [27:0] mant_r;
    logic [31:0] result_r;
    logic        ovf_r;
    logic        inx_r;
    pack_t       round_res;

    // Rounded 24-bit significand (hidden + fraction); bit 24 is the carry out.
    function automatic logic [24:0] rne_round(input logic [27:0] m);
        logic up;
        up = (ROUND_EN != 1'b0) && m[2] && (m[1] || m[0] || m[3]);
        return {1'b0, m[26:3]} + {24'd0, up};
    endfunction

    // Renormalize a rounding carry, saturate to infinity, and pack the word.
    function automatic pack_t pack_sat(input logic s, input logic [8:0] e,
                                       input logic [24:0] q, input logic inx);
        logic [8:0]  e_f;
        logic [23:0] sig;
        pack_t       p;
        if (q[24]) begin
            e_f = e + 9'd1;
            sig = q[24:1];
        end else begin
            e_f = e;
            sig = q[23:0];
        end
        if (e_f >= 9'd255) begin
            p.word = {s, 8'hFF, 23'h0};
            p.ovf  = 1'b1;
            p.inx  = 1'b1;
        end else begin
            // Hidden bit clear means denormal: exponent field is 0.
            p.word = {s, (sig[23] ? e_f[7:0] : 8'h00), sig[22:0]};
            p.ovf  = 1'b0;
            p.inx  = inx;
        end
        return p;
    endfunction

    assign round_res = pack_sat(sign_r, exp_r, rne_round(mant_r), |mant_r[2:0]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = (in_nan || in_inf) ? S_DONE : S_NORM;
            S_NORM: begin
                if (mant_r == 28'd0)                      state_nxt = S_ROUND;
                else if (mant_r[27])                      state_nxt = S_NORM;
                else if (!mant_r[26] && (exp_r > 9'd1))   state_nxt = S_NORM;
                else                                      state_nxt = S_ROUND;
            end
            S_ROUND: state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake and result outputs, all driven from registers.
    always_comb begin
        in_ready     = (state == S_IDLE);
        out_valid    = (state == S_DONE);
        out_result   = result_r;
        out_overflow = ovf_r;
        out_inexact  = inx_r;
    end

    // Working registers: capture on accept, then one normalize step per cycle.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (in_valid) begin
                sign_r <= in_sign;
                exp_r  <= (in_exp == 8'd0) ? 9'd1 : {1'b0, in_exp};
                mant_r <= in_mantis;
            end
            S_NORM: begin
                if (mant_r == 28'd0) begin
                    sign_r <= 1'b0;
                end else if (mant_r[27]) begin
                    // Bit shifted out is folded into sticky.
                    mant_r <= {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
                    exp_r  <= exp_r + 9'd1;
                end else if (!mant_r[26] && (exp_r > 9'd1)) begin
                    mant_r <= {mant_r[26:0], 1'b0};
                    exp_r  <= exp_r - 9'd1;
                end
            end
            default: ;
        endcase
    end

    // Result registers: specials load on accept, finite results in ROUND.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= 32'h0;
            ovf_r    <= 1'b0;
            inx_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    ovf_r <= 1'b0;
                    inx_r <= 1'b0;
                    if (in_nan)      result_r <= NAN_PATTERN;
                    else if (in_inf) result_r <= {in_sign, 8'hFF, 23'h0};
                end
                S_ROUND: begin
                    result_r <= round_res.word;
                    ovf_r    <= round_res.ovf;
                    inx_r    <= round_res.inx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_post_normalizer.sv
// Scoreboard bench for post_normalizer: a round-to-nearest-even instance and
// a truncating instance share the input stream; expected words come from a
// plain-arithmetic float model.
module tb_post_normalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [27:0] in_mantis = 28'd0;
    logic        in_inf = 1'b0;
    logic        in_nan = 1'b0;
    logic        out_ready;
    logic        rdy0, rdy1, vld0, vld1, ovf0, ovf1, inx0, inx1;
    logic [31:0] res0, res1;

    always #5 clk = ~clk;

    post_normalizer #(.ROUND_EN(1'b1), .NAN_PATTERN(32'h7FC00000)) u_rne (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_sign(in_sign), .in_exp(in_exp), .in_mantis(in_mantis),
        .in_inf(in_inf), .in_nan(in_nan), .out_valid(vld0), .out_ready(out_ready),
        .out_result(res0), .out_overflow(ovf0), .out_inexact(inx0));

    post_normalizer #(.ROUND_EN(1'b0), .NAN_PATTERN(32'h7FC00000)) u_trn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_sign(in_sign), .in_exp(in_exp), .in_mantis(in_mantis),
        .in_inf(in_inf), .in_nan(in_nan), .out_valid(vld1), .out_ready(out_ready),
        .out_result(res1), .out_overflow(ovf1), .out_inexact(inx1));

    typedef struct {
        logic [31:0] r0; logic o0; logic x0;
        logic [31:0] r1; logic o1; logic x1;
        int lat; int acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Reference: value-level normalize / round / pack.
    function automatic void model(input logic s, input logic [7:0] ex, input logic [27:0] mt,
                                  input logic inf, input logic nan, input bit ren,
                                  output logic [31:0] res, output logic ovf,
                                  output logic inx, output int lat);
        int     e, k, p;
        longint m, q, rem;
        logic   sg;
        ovf = 1'b0; inx = 1'b0; lat = 1;
        if (nan) begin res = 32'h7FC00000; return; end
        if (inf) begin res = {s, 8'hFF, 23'h0}; return; end
        e = (ex == 8'd0) ? 1 : int'(ex);
        m = longint'(mt);
        sg = s;
        k = 0;
        if (m == 0) begin
            sg = 1'b0;
        end else if (m >= (longint'(1) << 27)) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
            k = 1;
        end else begin
            p = 0;
            for (int i = 0; i < 27; i++) if (m[i]) p = i;
            k = 26 - p;
            if (k > e - 1) k = e - 1;
            m = m << k;
            e = e - k;
        end
        lat = 3 + k;
        q = m >> 3;
        rem = m & 7;
        inx = (rem != 0);
        if (ren && (rem > 4 || (rem == 4 && q[0]))) q = q + 1;
        if (q >= (longint'(1) << 24)) begin q = q >> 1; e = e + 1; end
        if (e >= 255) begin
            res = {sg, 8'hFF, 23'h0};
            ovf = 1'b1;
            inx = 1'b1;
        end else begin
            res = {sg, (q >= (longint'(1) << 23)) ? 8'(e) : 8'h00, q[22:0]};
        end
    endfunction

    task automatic issue(input logic s, input logic [7:0] ex, input logic [27:0] mt,
                         input logic inf, input logic nan);
        int n = 0;
        exp_t e;
        logic [31:0] r0, r1;
        logic o0, x0, o1, x1;
        int l0, l1;
        @(negedge clk);
        while (!rdy0 && n < 300) begin @(negedge clk); n++; end
        if (!rdy0) begin
            checks++; errors++;
            $display("FAIL issue_timeout: in_ready=%0b required 1", rdy0);
            return;
        end
        in_sign = s; in_exp = ex; in_mantis = mt; in_inf = inf; in_nan = nan;
        in_valid = 1'b1;
        model(s, ex, mt, inf, nan, 1'b1, r0, o0, x0, l0);
        model(s, ex, mt, inf, nan, 1'b0, r1, o1, x1, l1);
        e.r0 = r0; e.o0 = o0; e.x0 = x0;
        e.r1 = r1; e.o1 = o1; e.x1 = x1;
        e.lat = l0;
        @(posedge clk);
        #1;
        e.acc = cyc;
        sbq.push_back(e);
        in_valid = 1'b0;
        in_sign = 1'($urandom); in_exp = 8'($urandom); in_mantis = 28'($urandom);
        in_inf = 1'b0; in_nan = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !rdy0) && n < 2000) begin @(negedge clk); n++; end
        if (sbq.size() != 0 || !rdy0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending=%0d required 0", sbq.size());
        end
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output-side ready generator, changed away from both clock edges.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops an expectation on each new result, checks hold while stalled.
    initial begin
        logic        have;
        logic [31:0] held;
        exp_t        cur;
        have = 1'b0;
        held = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 1'b0;
            end else if (vld0) begin
                if (!have) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output: got %h with none pending", res0);
                    end else begin
                        cur = sbq.pop_front();
                        chk("result_rne", res0, cur.r0);
                        chk("overflow_rne", 32'(ovf0), 32'(cur.o0));
                        chk("inexact_rne", 32'(inx0), 32'(cur.x0));
                        chk("valid_trn", 32'(vld1), 32'd1);
                        chk("result_trn", res1, cur.r1);
                        chk("overflow_trn", 32'(ovf1), 32'(cur.o1));
                        chk("inexact_trn", 32'(inx1), 32'(cur.x1));
                        chk("latency", 32'(cyc + 1 - cur.acc), 32'(cur.lat));
                    end
                    have = 1'b1;
                    held = res0;
                end else begin
                    chk("hold_result", res0, held);
                    chk("hold_in_ready", 32'(rdy0), 32'd0);
                end
                if (out_ready) have = 1'b0;
            end
        end
    end

    // Stimulus.
    initial begin
        int n;
        logic [27:0] mt;
        int sp;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(rdy0), 32'd1);
        chk("reset_out_valid", 32'(vld0), 32'd0);
        chk("reset_result", res0, 32'h0);
        chk("reset_overflow", 32'(ovf0), 32'd0);
        chk("reset_inexact", 32'(inx0), 32'd0);
        rst = 1'b0;

        issue(1'b0, 8'd127, 28'h6000000, 1'b0, 1'b0);
        issue(1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0);
        issue(1'b0, 8'd254, 28'h8000000, 1'b0, 1'b0);
        issue(1'b0, 8'd127, 28'h0000008, 1'b0, 1'b0);
        issue(1'b1, 8'd127, 28'h0000000, 1'b0, 1'b0);
        issue(1'b0, 8'd127, 28'h4000004, 1'b0, 1'b0);
        issue(1'b0, 8'd127, 28'h400000C, 1'b0, 1'b0);
        issue(1'b0, 8'd127, 28'h7FFFFFC, 1'b0, 1'b0);
        issue(1'b0, 8'd1,   28'h2000000, 1'b0, 1'b0);
        issue(1'b0, 8'd0,   28'h2000000, 1'b0, 1'b0);
        issue(1'b1, 8'd127, 28'h1234567, 1'b1, 1'b1);
        issue(1'b1, 8'd100, 28'h1234567, 1'b1, 1'b0);
        issue(1'b0, 8'd3,   28'h0000011, 1'b0, 1'b0);
        drain();

        // Consumer stalls for five cycles.
        ready_mode = 1;
        issue(1'b0, 8'd130, 28'h5555555, 1'b0, 1'b0);
        n = 0;
        while (!vld0 && n < 100) begin @(negedge clk); n++; end
        if (!vld0) begin
            checks++; errors++;
            $display("FAIL stall_wait: out_valid=%0b required 1", vld0);
        end
        repeat (5) @(negedge clk);
        ready_mode = 0;
        drain();

        // Reset in the middle of normalization discards the operation.
        issue(1'b0, 8'd127, 28'h0000008, 1'b0, 1'b0);
        if (sbq.size() != 0) void'(sbq.pop_back());
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(rdy0), 32'd1);
        chk("abort_out_valid", 32'(vld0), 32'd0);
        chk("abort_in_ready_trn", 32'(rdy1), 32'd1);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Randomized traffic with a randomly stalling consumer.
        ready_mode = 2;
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 3))
                0:       mt = 28'($urandom);
                1:       mt = 28'($urandom) >> $urandom_range(0, 27);
                2:       mt = {2'b01, 26'($urandom)};
                default: mt = 28'($urandom) & 28'h000FFFF;
            endcase
            sp = $urandom_range(0, 15);
            issue(1'($urandom), 8'($urandom_range(0, 254)), mt, (sp <= 1), (sp == 0));
        end
        ready_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/post_normalizer.md
Name: post_normalizer

Overview:
- Back end of the float-add datapath: takes the raw 28-bit mantissa sum plus the shared exponent and sign produced after pre-adder alignment and addition.
- Normalizes the sum iteratively, one bit per cycle, then rounds (RNE) and packs an IEEE-754 single.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- ROUND_EN, 1, 1 = round-to-nearest-even; 0 = truncate (G/R/S discarded).
- NAN_PATTERN, 32'h7FC00000, word emitted when in_nan is set.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept an operation
- in_sign  in  1  result sign
- in_exp  in  8  shared (larger) biased exponent; 0 is treated as 1
- in_mantis  in  28  [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S
- in_inf  in  1  result is infinity (special bypass)
- in_nan  in  1  result is NaN (special bypass, priority over in_inf)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  32  packed {sign, exp[7:0], frac[22:0]}
- out_overflow  out  1  finite input rounded/normalized to infinity
- out_inexact  out  1  any nonzero G/R/S or shifted-out bit was discarded

Behaviour:
- Reset: state IDLE; in_ready=1, out_valid=0, out_result=0, out_overflow=0, out_inexact=0. Reset in any state aborts the operation with no output.
- in_ready=1 only in IDLE. Accept on in_valid & in_ready; latch sign, exp as 9-bit (max(in_exp,1)), mantissa, flags.
- States: IDLE, NORM, ROUND, DONE.
- IDLE -> DONE on accept with in_nan (out_result=NAN_PATTERN) or in_inf ({sign,8'hFF,23'h0}); out_overflow=0, out_inexact=0.
- IDLE -> NORM on any other accept.
- NORM, one action per cycle, in priority order:
  - mantissa==0: zero result {1'b0,31'h0}, go ROUND.
  - bit27=1: shift right 1, new S = old S | old bit0; exp+1; stay in NORM.
  - bit26=0 and exp>1: shift left 1, zero-fill; exp-1; stay in NORM.
  - otherwise go ROUND. If bit26=0 here (exp==1), the result is denormal and the exp field is 0.
- ROUND, one cycle:
  - inexact = G|R|S.
  - ROUND_EN=1: round up when G & (R | S | bit3). Add at bit3.
  - A carry into bit27 shifts right 1 and adds 1 to exp in the same cycle.
  - A denormal that rounds up into bit26 becomes exp field 1.
  - If exp >= 255: result {sign,8'hFF,0}, out_overflow=1, out_inexact=1.
  - Otherwise pack {sign, bit26 ? exp[7:0] : 8'h00, mant[25:3]}.
  - Go DONE.
- DONE: out_valid=1; out_result and flags held stable until out_valid & out_ready, then -> IDLE (in_ready=1 the next cycle; no same-cycle re-accept).
- Latency (accept edge to out_valid high): 3 + k cycles for the finite path, where k = number of NORM shift steps (0..26). Specials take 1 cycle.
- Outputs are registered only; no combinational path from in_* to out_*.
- in_valid while busy is ignored. Input data is not required to be held after accept.

Test Plan:
- in_exp=127, in_mantis=28'h6000000, out_ready=1 -> out_result=32'h3FC00000, out_valid 3 cycles after accept, out_inexact=0.
- in_exp=127, in_mantis=28'h8000000 (1.0+1.0 carry) -> 32'h40000000, latency 4. Repeat with in_exp=254 -> 32'h7F800000, out_overflow=1.
- in_exp=127, in_mantis=28'h0000008 (cancellation) -> 23 left shifts, exp 104, 32'h34000000, latency 26. in_mantis=0 -> 32'h00000000.
- Rounding: 28'h4000004 -> 32'h3F800000 (tie, even LSB kept), inexact=1. 28'h400000C -> 32'h3F800002. 28'h7FFFFFC with exp 127 -> rounds and carries to 32'h40000000. ROUND_EN=0 with 28'h400000C -> 32'h3F800001.
- Denormal: in_exp=1, in_mantis=28'h2000000 -> 32'h00400000 (no shift, exp field 0). in_exp=0, same mantissa -> same result.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles: out_result stable, in_ready=0.
  - in_nan=1 with in_inf=1 -> 32'h7FC00000 after 1 cycle.
  - rst asserted mid-NORM -> next cycle in_ready=1, out_valid=0, and no result is emitted.
